// File: rtl/soc_uart_tx.sv
// soc_uart_tx: transmit back end for the system UART.
// Bytes pushed from the register-block write path go into a small FIFO. A serialiser
// drains the FIFO and drives 8N1 frames onto tx: a start bit, eight data bits LSB
// first, then a stop bit, with no parity.
//
// Ports:
//   clk      system clock; all logic on posedge
//   rst      synchronous, active-high reset
//   we       write strobe; data_in is pushed when the FIFO is not full
//   data_in  byte to transmit
//   rdy      one-cycle pulse the cycle after an accepted push
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   level    current FIFO occupancy (0..FIFO_DEPTH)
//   ovf      sticky; a write arrived while full; cleared only by rst
//   busy     serialiser is not idle
//   tx       registered serial output; idle high
module soc_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [7:0]                    data_in,
  output logic                          rdy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          busy,
  output logic                          tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;

  // Serialiser state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic push;
  logic pop;

  assign full  = (count_q == DEPTH_L);
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdy   = rdy_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != ST_IDLE);
  assign tx    = tx_q;

  // full is taken from registered count, so a write while full loses even if the
  // serialiser pops in the same cycle.
  assign push = we & ~full;

  // Serialiser next state. pop is only raised when the FIFO holds data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx follows the current state one cycle later, which gives the two-edge
  // push-to-start-bit latency.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == ST_START) begin
      tx_d = 1'b0;
    end else if (state_q == ST_DATA) begin
      tx_d = shift_q[0];
    end
  end

  // FIFO pointer/count next state; pointers wrap naturally as FIFO_DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    rdy_d = push;
    ovf_d = ovf_q | (we & full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // Storage needs no reset: the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_soc_uart_tx.sv
// Directed testbench for soc_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_soc_uart_tx;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] data_in;
  logic       rdy;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       ovf;
  logic       busy;
  logic       tx;

  int n_cmp = 0;
  int n_err = 0;

  soc_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .data_in(data_in),
    .rdy    (rdy),
    .full   (full),
    .empty  (empty),
    .level  (level),
    .ovf    (ovf),
    .busy   (busy),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; values are then observed 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] bb [3];
  logic [7:0] ov [10];
  logic [9:0] f;

  initial begin
    rst     = 1'b1;
    we      = 1'b0;
    data_in = 8'h00;

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rdy", rdy, 0);

    // Single byte 0xA5; push accepted at edge E
    data_in = 8'hA5;
    we      = 1'b1;
    tick(1);
    we = 1'b0;
    check("single_rdy", rdy, 1);
    check("single_level", level, 1);
    check("single_tx_e0", tx, 1);
    check("single_busy_e0", busy, 0);
    tick(1);
    check("single_busy_e1", busy, 1);
    check("single_rdy_e1", rdy, 0);
    check("single_tx_e1", tx, 1);
    check("single_empty_e1", empty, 1);
    tick(1);
    check("single_tx_low_e2", tx, 0);
    tick(2);
    f = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("single_bit%0d", k), tx, f[k]);
      if (k < 9) tick(4);
    end
    check("single_busy_e40", busy, 1);
    tick(1);
    check("single_busy_e41", busy, 0);
    check("single_tx_idle", tx, 1);

    // Back-to-back 0x00, 0xFF, 0x55
    bb[0] = 8'h00;
    bb[1] = 8'hFF;
    bb[2] = 8'h55;
    we = 1'b1;
    data_in = bb[0];
    tick(1);
    check("b2b_level0", level, 1);
    data_in = bb[1];
    tick(1);
    check("b2b_level1", level, 1);
    data_in = bb[2];
    tick(1);
    we = 1'b0;
    check("b2b_level_peak", level, 2);
    tick(2);
    for (int k = 0; k < 30; k++) begin
      f = {1'b1, bb[k / 10], 1'b0};
      check($sformatf("b2b_bit%0d", k), tx, f[k % 10]);
      if (k < 29) tick(4);
    end
    check("b2b_busy_end", busy, 1);
    tick(1);
    check("b2b_idle", busy, 0);
    check("b2b_level_end", level, 0);

    // Overflow: one byte in flight, then 10 pushes mid-frame
    ov[0] = 8'h81; ov[1] = 8'h42; ov[2] = 8'h24; ov[3] = 8'h18; ov[4] = 8'hC3;
    ov[5] = 8'hE7; ov[6] = 8'h5A; ov[7] = 8'h0F; ov[8] = 8'h99; ov[9] = 8'h66;
    data_in = 8'h3C;
    we      = 1'b1;
    tick(1);
    we = 1'b0;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      data_in = ov[i];
      we      = 1'b1;
      tick(1);
      check($sformatf("ovf_rdy%0d", i), rdy, (i < 8) ? 1 : 0);
    end
    we = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_level", level, 8);
    check("ovf_flag", ovf, 1);
    tick(29);
    for (int k = 10; k < 90; k++) begin
      f = {1'b1, ov[k / 10 - 1], 1'b0};
      check($sformatf("ovf_bit%0d", k), tx, f[k % 10]);
      if (k < 89) tick(4);
    end
    tick(1);
    check("ovf_idle", busy, 0);
    check("ovf_empty", empty, 1);
    check("ovf_sticky", ovf, 1);

    // Full plus same-cycle pop
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("fp_ovf_cleared", ovf, 0);
    we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'h10 + 8'(i);
      tick(1);
    end
    we = 1'b0;
    check("fp_full", full, 1);
    check("fp_level8", level, 8);
    check("fp_ovf0", ovf, 0);
    tick(32);
    check("fp_full_prepop", full, 1);
    data_in = 8'hEE;
    we      = 1'b1;
    tick(1);
    we = 1'b0;
    check("fp_level7", level, 7);
    check("fp_ovf1", ovf, 1);
    check("fp_full0", full, 0);
    check("fp_rdy0", rdy, 0);

    // Reset mid-frame during DATA bit 3 with 3 bytes queued
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    we  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = (i == 0) ? 8'h00 : 8'h77;
      tick(1);
    end
    we = 1'b0;
    tick(14);
    check("mr_level_pre", level, 3);
    check("mr_busy_pre", busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mr_tx", tx, 1);
    check("mr_level", level, 0);
    check("mr_busy", busy, 0);
    check("mr_empty", empty, 1);
    tick(50);
    check("mr_tx_quiet", tx, 1);
    check("mr_busy_quiet", busy, 0);
    check("mr_empty_quiet", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
